// File: rtl/bp_pkg.sv
// Shared definitions for the gshare/bimodal branch predictor.
//   bp_mode_t      : indexing scheme selector (PC only, or PC xor GHR)
//   BP_DEF_*       : default parameter values
//   BP_STAT_MAX    : saturation value of the statistics counters
//   bp_weak_nt()   : weakly-not-taken counter value for a given counter width
package bp_pkg;

  typedef enum logic {
    BP_BIMODAL = 1'b0,
    BP_GSHARE  = 1'b1
  } bp_mode_t;

  localparam int          BP_DEF_INDEX_BITS = 6;
  localparam int          BP_DEF_HIST_BITS  = 6;
  localparam int          BP_DEF_CTR_BITS   = 2;
  localparam logic [31:0] BP_STAT_MAX       = 32'hFFFF_FFFF;

  // 2^(ctr_bits-1)-1: the largest value whose MSB is still 0.
  function automatic logic [3:0] bp_weak_nt(input int ctr_bits);
    return 4'((1 << (ctr_bits - 1)) - 1);
  endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern history table: an array of saturating counters.
//   clk, reset : clock, asynchronous active-high reset (all entries -> weakly-not-taken)
//   rd_idx     : combinational read address
//   rd_ctr     : counter value at rd_idx (pre-update value on a same-cycle write)
//   wr_en      : apply one saturating step at wr_idx on the next edge
//   wr_idx     : entry to update
//   wr_taken   : 1 = step up (saturate at max), 0 = step down (saturate at 0)
module bp_pht
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = BP_DEF_INDEX_BITS,
  parameter int CTR_BITS   = BP_DEF_CTR_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic [CTR_BITS-1:0]   rd_ctr,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic                  wr_taken
);

  localparam int                 ENTRIES  = 1 << INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(bp_weak_nt(CTR_BITS));

  logic [CTR_BITS-1:0] ctr_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_d [ENTRIES];

  // Reads see the registered array, so a same-cycle write is not forwarded.
  assign rd_ctr = ctr_q[rd_idx];

  always_comb begin
    ctr_d = ctr_q;
    if (wr_en) begin
      if (wr_taken && (ctr_q[wr_idx] != CTR_MAX)) begin
        ctr_d[wr_idx] = ctr_q[wr_idx] + CTR_BITS'(1);
      end else if (!wr_taken && (ctr_q[wr_idx] != '0)) begin
        ctr_d[wr_idx] = ctr_q[wr_idx] - CTR_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= CTR_INIT;
      end
    end else begin
      ctr_q <= ctr_d;
    end
  end

endmodule

// File: rtl/branch_predictor_gshare.sv
// Global-history branch predictor (gshare, or bimodal when MODE=BP_BIMODAL).
//   clk, reset     : clock, asynchronous active-high reset
//   lookup_en      : fetch holds a branch lookup this cycle
//   pc_f           : fetch PC
//   pred_taken_f   : prediction (MSB of the indexed counter), combinational
//   pred_idx_f     : PHT index used, carried down the pipe for the update
//   ghr_f          : GHR before this lookup's shift, carried down the pipe
//   update_en      : a branch resolved this cycle
//   update_idx     : carried pred_idx_f of the resolving branch
//   update_ghr     : carried ghr_f of the resolving branch
//   update_taken   : resolved outcome
//   mispred        : resolving branch was mispredicted
//   stats_clear    : synchronous clear of both statistics counters
//   branch_count   : resolved branches (saturating)
//   mispred_count  : mispredicted branches (saturating)
//
// Qualifier semantics: there is no backpressure. lookup_en and update_en are
// single-cycle valid strobes that are consumed on the clock edge at which they
// are high; mispred, update_* and the lookup outputs are meaningful only while
// their strobe is high.
module branch_predictor_gshare
  import bp_pkg::*;
#(
  parameter int       INDEX_BITS = BP_DEF_INDEX_BITS,
  parameter int       HIST_BITS  = BP_DEF_HIST_BITS,
  parameter int       CTR_BITS   = BP_DEF_CTR_BITS,
  parameter bp_mode_t MODE       = BP_GSHARE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  lookup_en,
  input  logic [31:0]           pc_f,
  output logic                  pred_taken_f,
  output logic [INDEX_BITS-1:0] pred_idx_f,
  output logic [HIST_BITS-1:0]  ghr_f,
  input  logic                  update_en,
  input  logic [INDEX_BITS-1:0] update_idx,
  input  logic [HIST_BITS-1:0]  update_ghr,
  input  logic                  update_taken,
  input  logic                  mispred,
  input  logic                  stats_clear,
  output logic [31:0]           branch_count,
  output logic [31:0]           mispred_count
);

  logic [HIST_BITS-1:0]  ghr_q, ghr_d;
  logic [31:0]           branch_count_q, branch_count_d;
  logic [31:0]           mispred_count_q, mispred_count_d;
  logic [INDEX_BITS-1:0] base_idx;
  logic [INDEX_BITS-1:0] lookup_idx;
  logic [CTR_BITS-1:0]   rd_ctr;

  // PC bits outside the index window do not take part in the lookup.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_f[31:INDEX_BITS+2], pc_f[1:0]};

  // Word-aligned PC bits form the base index; gshare folds in the history.
  assign base_idx = pc_f[INDEX_BITS+1:2];

  always_comb begin
    lookup_idx = base_idx;
    if (MODE == BP_GSHARE) begin
      lookup_idx = base_idx ^ INDEX_BITS'(ghr_q);
    end
  end

  bp_pht #(
    .INDEX_BITS (INDEX_BITS),
    .CTR_BITS   (CTR_BITS)
  ) u_pht (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (lookup_idx),
    .rd_ctr   (rd_ctr),
    .wr_en    (update_en),
    .wr_idx   (update_idx),
    .wr_taken (update_taken)
  );

  assign pred_taken_f = rd_ctr[CTR_BITS-1];
  assign pred_idx_f   = lookup_idx;
  assign ghr_f        = ghr_q;

  // History shift. Concatenating one bit and truncating back to HIST_BITS
  // drops the oldest bit; with HIST_BITS=1 this leaves just the new bit.
  // A misprediction rebuilds history from the resolving branch's snapshot
  // and overrides any speculative shift from a same-cycle lookup.
  always_comb begin
    ghr_d = ghr_q;
    if (update_en && mispred) begin
      ghr_d = HIST_BITS'({update_ghr, update_taken});
    end else if (lookup_en) begin
      ghr_d = HIST_BITS'({ghr_q, pred_taken_f});
    end
  end

  // Statistics: saturating increments, clear wins over a same-cycle increment.
  always_comb begin
    branch_count_d  = branch_count_q;
    mispred_count_d = mispred_count_q;
    if (stats_clear) begin
      branch_count_d  = '0;
      mispred_count_d = '0;
    end else if (update_en) begin
      if (branch_count_q != BP_STAT_MAX) begin
        branch_count_d = branch_count_q + 32'd1;
      end
      if (mispred && (mispred_count_q != BP_STAT_MAX)) begin
        mispred_count_d = mispred_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghr_q           <= '0;
      branch_count_q  <= '0;
      mispred_count_q <= '0;
    end else begin
      ghr_q           <= ghr_d;
      branch_count_q  <= branch_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign branch_count  = branch_count_q;
  assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Bench for branch_predictor_gshare with default parameters: directed checks
// of the documented examples, then randomized traffic checked every cycle
// against a behavioural model of the predictor.
module tb_branch_predictor_gshare;
  import bp_pkg::*;

  localparam int IB      = 6;
  localparam int HB      = 6;
  localparam int ENTRIES = 64;
  localparam int CMAX    = 3;   // 2-bit counter maximum
  localparam int WNT     = 1;   // weakly-not-taken
  localparam int THRESH  = 2;   // counter >= THRESH predicts taken

  // ---------------- clock / reset / signals ----------------
  logic          clk;
  logic          reset;
  logic          lookup_en;
  logic [31:0]   pc_f;
  logic          pred_taken_f;
  logic [IB-1:0] pred_idx_f;
  logic [HB-1:0] ghr_f;
  logic          update_en;
  logic [IB-1:0] update_idx;
  logic [HB-1:0] update_ghr;
  logic          update_taken;
  logic          mispred;
  logic          stats_clear;
  logic [31:0]   branch_count;
  logic [31:0]   mispred_count;

  logic          bi_pred_taken_f;
  logic [IB-1:0] bi_pred_idx_f;
  logic [HB-1:0] bi_ghr_f;
  logic [31:0]   bi_branch_count;
  logic [31:0]   bi_mispred_count;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  branch_predictor_gshare #(
    .INDEX_BITS (IB), .HIST_BITS (HB), .CTR_BITS (2), .MODE (BP_GSHARE)
  ) dut (
    .clk (clk), .reset (reset), .lookup_en (lookup_en), .pc_f (pc_f),
    .pred_taken_f (pred_taken_f), .pred_idx_f (pred_idx_f), .ghr_f (ghr_f),
    .update_en (update_en), .update_idx (update_idx), .update_ghr (update_ghr),
    .update_taken (update_taken), .mispred (mispred), .stats_clear (stats_clear),
    .branch_count (branch_count), .mispred_count (mispred_count)
  );

  branch_predictor_gshare #(
    .INDEX_BITS (IB), .HIST_BITS (HB), .CTR_BITS (2), .MODE (BP_BIMODAL)
  ) dut_bi (
    .clk (clk), .reset (reset), .lookup_en (lookup_en), .pc_f (pc_f),
    .pred_taken_f (bi_pred_taken_f), .pred_idx_f (bi_pred_idx_f), .ghr_f (bi_ghr_f),
    .update_en (update_en), .update_idx (update_idx), .update_ghr (update_ghr),
    .update_taken (update_taken), .mispred (mispred), .stats_clear (stats_clear),
    .branch_count (bi_branch_count), .mispred_count (bi_mispred_count)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int     m_pht [ENTRIES];
  int     m_ghr;
  longint m_bc;
  longint m_mc;

  function automatic int m_idx(input logic [31:0] pc, input int ghr);
    int base;
    base = int'((pc >> 2) & 32'h3F);
    return base ^ ghr;
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    return m_pht[m_idx(pc, m_ghr)] >= THRESH;
  endfunction

  always @(posedge clk or posedge reset) begin : model
    bit p;
    int ui;
    if (reset) begin
      foreach (m_pht[i]) m_pht[i] = WNT;
      m_ghr = 0;
      m_bc  = 0;
      m_mc  = 0;
    end else begin
      p  = m_pred(pc_f);
      ui = int'(update_idx);
      if (update_en) begin
        if (update_taken) m_pht[ui] = (m_pht[ui] < CMAX) ? m_pht[ui] + 1 : CMAX;
        else              m_pht[ui] = (m_pht[ui] > 0)    ? m_pht[ui] - 1 : 0;
        if (m_bc < 64'hFFFF_FFFF) m_bc++;
        if (mispred && m_mc < 64'hFFFF_FFFF) m_mc++;
      end
      if (stats_clear) begin
        m_bc = 0;
        m_mc = 0;
      end
      if (update_en && mispred) m_ghr = ((int'(update_ghr) * 2) + int'(update_taken)) % ENTRIES;
      else if (lookup_en)       m_ghr = ((m_ghr * 2) + int'(p)) % ENTRIES;
    end
  end

  // ---------------- per-cycle compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("pred_taken_f",  32'(pred_taken_f),  32'(m_pred(pc_f)));
      check("pred_idx_f",    32'(pred_idx_f),    32'(m_idx(pc_f, m_ghr)));
      check("ghr_f",         32'(ghr_f),         32'(m_ghr));
      check("branch_count",  branch_count,       32'(m_bc));
      check("mispred_count", mispred_count,      32'(m_mc));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    lookup_en    = 1'b0;
    update_en    = 1'b0;
    update_idx   = '0;
    update_ghr   = '0;
    update_taken = 1'b0;
    mispred      = 1'b0;
    stats_clear  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic upd(input int idx, input bit taken, input bit mp);
    update_en    = 1'b1;
    update_idx   = IB'(idx);
    update_taken = taken;
    mispred      = mp;
    tick();
    idle();
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    pc_f  = 32'h0040_0010;
    idle();
    tick();
    tick();
    reset  = 1'b0;
    chk_en = 1'b1;

    // Reset state at pc 0x0040_0010.
    settle();
    check("rst pred",   32'(pred_taken_f), 32'd0);
    check("rst idx",    32'(pred_idx_f),   32'd4);
    check("rst ghr",    32'(ghr_f),        32'd0);
    check("rst bcount", branch_count,      32'd0);
    check("rst mcount", mispred_count,     32'd0);

    // Training idx 4: 1 -> 2 -> 3 -> 3, then 3 -> 2 -> 1.
    upd(4, 1'b1, 1'b0);
    settle();
    check("train1 pred", 32'(pred_taken_f), 32'd1);
    check("train1 model ctr", 32'(m_pht[4]), 32'd2);
    upd(4, 1'b1, 1'b0);
    upd(4, 1'b1, 1'b0);
    settle();
    check("train3 pred", 32'(pred_taken_f), 32'd1);
    check("train3 model ctr", 32'(m_pht[4]), 32'd3);
    upd(4, 1'b0, 1'b0);
    settle();
    check("untrain1 pred", 32'(pred_taken_f), 32'd1);
    upd(4, 1'b0, 1'b0);
    settle();
    check("untrain2 pred", 32'(pred_taken_f), 32'd0);
    check("untrain2 model ctr", 32'(m_pht[4]), 32'd1);
    check("train bcount", branch_count, 32'd5);

    // Recovery beats a same-cycle lookup shift.
    lookup_en    = 1'b1;
    update_en    = 1'b1;
    mispred      = 1'b1;
    update_ghr   = 6'b000101;
    update_taken = 1'b1;
    update_idx   = 6'd4;
    tick();
    idle();
    settle();
    check("recover ghr",     32'(ghr_f),        32'b001011);
    check("recover bi ghr",  32'(bi_ghr_f),     32'b001011);
    check("gshare idx",      32'(pred_idx_f),   32'b001111);
    check("bimodal idx",     32'(bi_pred_idx_f), 32'b000100);
    check("recover mcount",  mispred_count,     32'd1);

    // Statistics: 10 updates with 3 mispredictions, then clear with an update.
    do_reset();
    for (int i = 0; i < 10; i++) upd($urandom_range(0, 63), 1'($urandom_range(0, 1)), i < 3);
    settle();
    check("stats bcount", branch_count,  32'd10);
    check("stats mcount", mispred_count, 32'd3);
    update_en   = 1'b1;
    mispred     = 1'b1;
    stats_clear = 1'b1;
    tick();
    idle();
    settle();
    check("clear bcount", branch_count,  32'd0);
    check("clear mcount", mispred_count, 32'd0);

    // Asynchronous reset pulse between edges after training.
    upd(4, 1'b1, 1'b1);
    upd(4, 1'b1, 1'b0);
    lookup_en = 1'b1;
    tick();
    tick();
    idle();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check("pulse pred",   32'(pred_taken_f), 32'd0);
    check("pulse idx",    32'(pred_idx_f),   32'd4);
    check("pulse ghr",    32'(ghr_f),        32'd0);
    check("pulse bcount", branch_count,      32'd0);
    check("pulse mcount", mispred_count,     32'd0);
    settle();
    upd(4, 1'b1, 1'b0);
    settle();
    check("post-pulse pred", 32'(pred_taken_f), 32'd1);

    // Randomized traffic; a narrow update index range exercises saturation.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      pc_f       = $urandom;
      lookup_en  = 1'($urandom_range(0, 1));
      update_en  = ($urandom_range(0, 99) < 60);
      update_idx = ($urandom_range(0, 1) == 0) ? IB'($urandom_range(0, 7))
                                               : IB'($urandom_range(0, 63));
      update_ghr   = HB'($urandom_range(0, 63));
      update_taken = 1'($urandom_range(0, 1));
      mispred      = 1'($urandom_range(0, 1));
      stats_clear  = ($urandom_range(0, 63) == 0);
      if (cyc == 1500) begin
        reset = 1'b1;
        #2;
        reset = 1'b0;
      end
      tick();
    end
    idle();
    settle();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/branch_predictor_gshare.md
BRANCH_PREDICTOR_GSHARE -- requirements
Module: branch_predictor_gshare

Interface
REQ-001 Parameter INDEX_BITS, default 6, log2 of pattern history table (PHT) entries.
REQ-002 Parameter HIST_BITS, default 6, global history register (GHR) width; legal range 1..INDEX_BITS.
REQ-003 Parameter CTR_BITS, default 2, saturating counter width; legal range 1..4.
REQ-004 Parameter MODE, default BP_GSHARE; BP_BIMODAL indexes by PC only, BP_GSHARE indexes by PC xor GHR.
REQ-005 Clocking: one clock, clk; reset is asynchronous and active-high, named reset.
REQ-006 clk  in  1  processor clock.
REQ-007 reset  in  1  asynchronous active-high reset.
REQ-008 lookup_en  in  1  fetch stage holds a branch lookup this cycle (not asserted while stall_f).
REQ-009 pc_f  in  32  fetch PC.
REQ-010 pred_taken_f  out  1  prediction for pc_f.
REQ-011 pred_idx_f  out  INDEX_BITS  PHT index used; carried down the pipe for update.
REQ-012 ghr_f  out  HIST_BITS  GHR snapshot before this lookup's shift; carried down the pipe.
REQ-013 update_en  in  1  decode-stage branch resolved.
REQ-014 update_idx  in  INDEX_BITS  carried pred_idx_f.
REQ-015 update_ghr  in  HIST_BITS  carried ghr_f.
REQ-016 update_taken  in  1  resolved outcome.
REQ-017 mispred  in  1  prediction was wrong; qualified by update_en.
REQ-018 stats_clear  in  1  synchronous clear of statistics.
REQ-019 branch_count  out  32  resolved branches.
REQ-020 mispred_count  out  32  mispredicted branches.

Function
REQ-021 Index: base = pc_f[INDEX_BITS+1:2]; gshare XORs it with GHR zero-extended to INDEX_BITS; bimodal uses base.
REQ-022 pred_taken_f, pred_idx_f, ghr_f are combinational from pc_f, the current GHR and the registered PHT (zero-cycle lookup).
REQ-023 pred_taken_f = MSB of the indexed counter.
REQ-024 Update (update_en=1): counter at update_idx increments if update_taken and below max, decrements if not taken and above 0, otherwise holds; written at next clock edge.
REQ-025 Same-cycle lookup and update to one index: lookup returns pre-update value.
REQ-026 GHR, lookup_en=1 and no recovery: GHR <= {GHR[HIST_BITS-2:0], pred_taken_f}.
REQ-027 GHR, update_en & mispred: GHR <= {update_ghr[HIST_BITS-2:0], update_taken}; takes priority over a same-cycle lookup shift.
REQ-028 HIST_BITS=1 shift degenerates to GHR <= new bit.
REQ-029 branch_count +1 per update_en; mispred_count +1 per update_en & mispred; both saturate at 32'hFFFF_FFFF.
REQ-030 stats_clear zeroes both counts next edge, overriding a same-cycle increment.
REQ-031 mispred without update_en is ignored.

Reset
REQ-032 reset asserted: every counter to weakly-not-taken (2^(CTR_BITS-1)-1), GHR=0, both counts=0, immediately without a clock edge.
REQ-033 Reset mid-operation discards any in-flight update; first edge after deassertion behaves as from power-up.

Structure
REQ-034 Package bp_pkg holds the bp_mode_t enum (BP_BIMODAL, BP_GSHARE), default parameter constants and the weakly-not-taken init expression.
REQ-035 Sub-module bp_pht: parametrised counter array with one combinational read port and one registered saturating-update port.

Verification (defaults)
REQ-036 Reset, pc_f=0x0040_0010 -> pred_taken_f=0, pred_idx_f=4, ghr_f=0, counts 0.
REQ-037 Three taken updates idx 4 -> counter 1,2,3,3; pred_taken_f=1; two not-taken -> 1, pred 0.
REQ-038 update_en=mispred=1, update_ghr=6'b000101, update_taken=1, lookup_en=1 same cycle -> GHR=6'b001011.
REQ-039 GHR=6'b001011, pc_f=0x0040_0010 -> pred_idx_f=6'b001111 (gshare); 6'b000100 (bimodal).
REQ-040 10 updates, 3 mispred -> branch_count=10, mispred_count=3; stats_clear with concurrent update -> both 0.
REQ-041 reset pulsed between clock edges after training -> all state at reset values before next edge.
